// File: rtl/adc_seq_pkg.sv
// ----------------------------------------------------------------------------
// adc_seq_pkg
// Shared types and constants for the ADC scan sequencer and its frame shifter:
//   seq_state_t  - sequencer FSM states
//   FRAME_BITS   - sclk periods per ADC frame
//   DATA_W/CH_W  - conversion result and channel address widths
//   ADDR_*/DATA_*- 1-based bit periods carrying the address / result bits
//   din_bit()    - address bit driven in a given bit period
//   lowest_ch()  - lowest enabled channel of a mask
// ----------------------------------------------------------------------------
package adc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } seq_state_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned CH_W       = 3;
    localparam int unsigned NUM_CH     = 8;

    // bit-period counter holds 1..FRAME_BITS
    localparam int unsigned PER_W = 5;

    localparam logic [PER_W-1:0] ADDR_FIRST = 5'd3;
    localparam logic [PER_W-1:0] ADDR_LAST  = 5'd5;
    localparam logic [PER_W-1:0] DATA_FIRST = 5'd5;
    localparam logic [PER_W-1:0] DATA_LAST  = 5'd16;

    // Periods 3,4,5 carry ADD[2],ADD[1],ADD[0]; every other period is 0.
    function automatic logic din_bit(logic [PER_W-1:0] period, logic [CH_W-1:0] addr);
        logic             b;
        logic [PER_W-1:0] off;
        b   = 1'b0;
        off = ADDR_LAST - period;
        if (period >= ADDR_FIRST && period <= ADDR_LAST) begin
            b = addr[off[1:0]];
        end
        return b;
    endfunction

    function automatic logic [CH_W-1:0] lowest_ch(logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (mask[3'(i - 1)]) ch = CH_W'(i - 1);
        end
        return ch;
    endfunction

endpackage

// File: rtl/adc_frame_shifter.sv
// ----------------------------------------------------------------------------
// adc_frame_shifter
// Generates one 16-period sclk frame: each period is a low half followed by a
// high half of SCLK_HALF clk cycles. din changes on sclk falling edges, dout
// is sampled on the clk edge that drives sclk high.
// Ports:
//   clk, reset_b     - clock, asynchronous active-low reset
//   frame_start_i    - begin a frame (accepted when idle or on frame_end_o)
//   addr_i           - channel address sent in the frame being started
//   dout_i           - ADC serial data
//   sclk_o, din_o    - registered ADC clock / address line
//   data_o           - 12-bit result shifted in during periods 5..16
//   data_valid_o     - one-cycle pulse after DB0 has been captured
//   frame_end_o      - this cycle closes the high half of period 16
// ----------------------------------------------------------------------------
module adc_frame_shifter
    import adc_seq_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              frame_start_i,
    input  logic [CH_W-1:0]   addr_i,
    input  logic              dout_i,
    output logic              sclk_o,
    output logic              din_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              frame_end_o
);

    localparam logic [3:0]       HALF_LAST = 4'(SCLK_HALF - 1);
    localparam logic [PER_W-1:0] PER_FIRST = 5'd1;
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(FRAME_BITS);

    logic              active_q;
    logic              sclk_q;
    logic              din_q;
    logic              valid_q;
    logic [3:0]        half_cnt_q;
    logic [PER_W-1:0]  period_q;
    logic [CH_W-1:0]   addr_q;
    logic [DATA_W-1:0] data_q;
    logic              half_end;

    assign half_end    = active_q && (half_cnt_q == HALF_LAST);
    assign frame_end_o = half_end && sclk_q && (period_q == PER_LAST);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            active_q   <= 1'b0;
            sclk_q     <= 1'b1;
            din_q      <= 1'b0;
            valid_q    <= 1'b0;
            half_cnt_q <= '0;
            period_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            // a start on frame_end_o chains frames with no idle sclk half
            if (frame_start_i && (!active_q || frame_end_o)) begin
                active_q   <= 1'b1;
                sclk_q     <= 1'b0;
                period_q   <= PER_FIRST;
                half_cnt_q <= '0;
                addr_q     <= addr_i;
                din_q      <= din_bit(PER_FIRST, addr_i);
            end else if (active_q) begin
                if (!half_end) begin
                    half_cnt_q <= half_cnt_q + 4'd1;
                end else begin
                    half_cnt_q <= '0;
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                        if (period_q >= DATA_FIRST) begin
                            data_q <= {data_q[DATA_W-2:0], dout_i};
                        end
                        if (period_q == DATA_LAST) valid_q <= 1'b1;
                    end else if (period_q == PER_LAST) begin
                        active_q <= 1'b0;
                        din_q    <= 1'b0;
                    end else begin
                        sclk_q   <= 1'b0;
                        period_q <= period_q + 5'd1;
                        din_q    <= din_bit(period_q + 5'd1, addr_q);
                    end
                end
            end
        end
    end

    assign sclk_o       = sclk_q;
    assign din_o        = din_q;
    assign data_o       = data_q;
    assign data_valid_o = valid_q;

endmodule

// File: rtl/adc_sequencer.sv
// ----------------------------------------------------------------------------
// adc_sequencer
// Scans the enabled channels of a serial 8-channel ADC. A scan of N channels
// runs N+1 back-to-back frames under one cs_b assertion; the ADC returns the
// conversion of the previous frame's address, so frame 0 data is dropped and
// the last address is repeated to flush the pipeline.
// Ports:
//   clk, reset_b               - clock, asynchronous active-low reset
//   start                      - scan request pulse
//   ch_enable                  - channel mask, latched on an accepted start
//   dout                       - ADC serial data
//   sclk, cs_b, din            - ADC serial interface (sclk/cs_b idle high)
//   sample_valid               - pulse: sample_ch/sample_data updated
//   sample_ch, sample_data     - tagged conversion result
//   scan_done                  - pulse with the final sample of a scan
//   busy                       - scan in progress
//   overrun                    - pulse one cycle after a start while busy
// ----------------------------------------------------------------------------
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              dout,
    output logic              sclk,
    output logic              cs_b,
    output logic              din,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [DATA_W-1:0] sample_data,
    output logic              scan_done,
    output logic              busy,
    output logic              overrun
);

    localparam logic [4:0] SETUP_LAST = 5'(SCLK_HALF - 1);
    localparam logic [4:0] GAP_LAST   = 5'(2 * SCLK_HALF - 1);

    seq_state_t        state_q;
    logic [4:0]        cnt_q;
    logic [NUM_CH-1:0] rem_q;
    logic [CH_W-1:0]   cur_addr_q;
    logic [CH_W-1:0]   prev_addr_q;
    logic              first_frame_q;
    logic              last_frame_q;
    logic              cs_b_q;
    logic              busy_q;
    logic              overrun_q;
    logic              sample_valid_q;
    logic              scan_done_q;
    logic [CH_W-1:0]   sample_ch_q;
    logic [DATA_W-1:0] sample_data_q;

    logic              setup_done;
    logic              frame_start;
    logic              frame_end;
    logic [CH_W-1:0]   next_ch;
    logic [CH_W-1:0]   frame_addr;
    logic [DATA_W-1:0] shift_data;
    logic              shift_valid;

    assign next_ch     = lowest_ch(rem_q);
    assign setup_done  = (state_q == ST_SETUP) && (cnt_q == SETUP_LAST);
    assign frame_start = setup_done ||
                         ((state_q == ST_SHIFT) && frame_end && !last_frame_q);
    // once every channel has been sent, repeat the last one to flush the ADC
    assign frame_addr  = (rem_q != '0) ? next_ch : cur_addr_q;

    adc_frame_shifter #(
        .SCLK_HALF(SCLK_HALF)
    ) u_shifter (
        .clk          (clk),
        .reset_b      (reset_b),
        .frame_start_i(frame_start),
        .addr_i       (frame_addr),
        .dout_i       (dout),
        .sclk_o       (sclk),
        .din_o        (din),
        .data_o       (shift_data),
        .data_valid_o (shift_valid),
        .frame_end_o  (frame_end)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            cur_addr_q     <= '0;
            prev_addr_q    <= '0;
            first_frame_q  <= 1'b0;
            last_frame_q   <= 1'b0;
            cs_b_q         <= 1'b1;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
        end else begin
            sample_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            overrun_q      <= start && busy_q;

            if (frame_start) begin
                cur_addr_q    <= frame_addr;
                prev_addr_q   <= cur_addr_q;
                first_frame_q <= setup_done;
                if (rem_q != '0) rem_q[next_ch] <= 1'b0;
                else             last_frame_q   <= 1'b1;
            end

            // the result of frame k belongs to the address sent in frame k-1
            if (shift_valid && !first_frame_q) begin
                sample_valid_q <= 1'b1;
                sample_ch_q    <= prev_addr_q;
                sample_data_q  <= shift_data;
                scan_done_q    <= last_frame_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start && (ch_enable != '0)) begin
                        state_q      <= ST_SETUP;
                        rem_q        <= ch_enable;
                        cs_b_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                        last_frame_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (setup_done) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (frame_end && last_frame_q) begin
                        state_q <= ST_GAP;
                        cs_b_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_GAP: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cs_b         = cs_b_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign sample_valid = sample_valid_q;
    assign scan_done    = scan_done_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;

endmodule
